// File: rtl/ysyx_23060061_wbu_if.sv
// Handshake and bus bundle between the execute stage, data memory read channel,
// register file write port and the write-back unit.
interface ysyx_23060061_wbu_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_rd;
  logic                  in_wen;
  logic                  in_is_load;
  logic [2:0]            in_funct3;
  logic [DATA_WIDTH-1:0] in_result;

  logic                  mem_rvalid;
  logic                  mem_rready;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rerr;

  logic [DATA_WIDTH-1:0] rf_wdata;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic                  rf_wen;
  logic                  wb_done;
  logic                  wb_err;

  modport master (
    output in_valid, in_rd, in_wen, in_is_load, in_funct3, in_result,
    output mem_rvalid, mem_rdata, mem_rerr,
    input  in_ready, mem_rready, rf_wdata, rf_waddr, rf_wen, wb_done, wb_err
  );

  modport slave (
    input  in_valid, in_rd, in_wen, in_is_load, in_funct3, in_result,
    input  mem_rvalid, mem_rdata, mem_rerr,
    output in_ready, mem_rready, rf_wdata, rf_waddr, rf_wen, wb_done, wb_err
  );
endinterface

// File: rtl/ysyx_23060061_wbu.sv
// Write-back unit: takes one retired instruction, waits for load data when needed,
// then performs a single-cycle register file write and signals retirement.
module ysyx_23060061_wbu #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input logic                   clk,
  input logic                   rst,
  ysyx_23060061_wbu_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                  wen_q, wen_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            off_q, off_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;

  // Select and extend the addressed byte/halfword; a halfword at offset 3 keeps zero fill.
  function automatic logic [DATA_WIDTH-1:0] load_extend(
    input logic [2:0]            f3,
    input logic [1:0]            off,
    input logic [DATA_WIDTH-1:0] rdata
  );
    logic [DATA_WIDTH-1:0] sh;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  load_extend = {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
      3'b100:  load_extend = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
      3'b001:  load_extend = {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
      3'b101:  load_extend = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
      default: load_extend = rdata;
    endcase
  endfunction

  // State and capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_q     <= {ADDR_WIDTH{1'b0}};
      wen_q    <= 1'b0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      data_q   <= {DATA_WIDTH{1'b0}};
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      wen_q    <= wen_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  // Next-state and capture logic.
  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    wen_d    = wen_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    data_d   = data_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          rd_d     = bus.in_rd;
          wen_d    = bus.in_wen;
          funct3_d = bus.in_funct3;
          off_d    = bus.in_result[1:0];
          data_d   = bus.in_result;
          err_d    = 1'b0;
          state_d  = bus.in_is_load ? WAIT_MEM : WRITE;
        end else begin
          state_d  = IDLE;
        end
      end
      WAIT_MEM: begin
        if (bus.mem_rvalid) begin
          data_d  = load_extend(funct3_q, off_q, bus.mem_rdata);
          err_d   = bus.mem_rerr;
          state_d = WRITE;
        end else begin
          state_d = WAIT_MEM;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register only.
  always_comb begin
    bus.in_ready   = 1'b0;
    bus.mem_rready = 1'b0;
    bus.rf_wen     = 1'b0;
    bus.wb_done    = 1'b0;
    bus.wb_err     = 1'b0;
    case (state_q)
      IDLE:     bus.in_ready   = 1'b1;
      WAIT_MEM: bus.mem_rready = 1'b1;
      WRITE: begin
        // x0 is not hard-wired in the register file, so it must be masked here.
        bus.rf_wen  = wen_q && (rd_q != {ADDR_WIDTH{1'b0}}) && !err_q;
        bus.wb_done = 1'b1;
        bus.wb_err  = err_q;
      end
      default: bus.in_ready = 1'b0;
    endcase
  end

  assign bus.rf_waddr = rd_q;
  assign bus.rf_wdata = data_q;

endmodule

// File: tb/tb_ysyx_23060061_wbu.sv
// Directed self-checking bench for the write-back unit.
module tb_ysyx_23060061_wbu;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  ysyx_23060061_wbu_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  ysyx_23060061_wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic rdy, input logic mrdy, input logic wen,
                          input logic done, input logic err);
    chk({tag, ".in_ready"},   {31'd0, bus.in_ready},   {31'd0, rdy});
    chk({tag, ".mem_rready"}, {31'd0, bus.mem_rready}, {31'd0, mrdy});
    chk({tag, ".rf_wen"},     {31'd0, bus.rf_wen},     {31'd0, wen});
    chk({tag, ".wb_done"},    {31'd0, bus.wb_done},    {31'd0, done});
    chk({tag, ".wb_err"},     {31'd0, bus.wb_err},     {31'd0, err});
  endtask

  task automatic present(input logic [4:0] rd, input logic wen, input logic is_load,
                         input logic [2:0] f3, input logic [31:0] res);
    bus.in_valid   = 1'b1;
    bus.in_rd      = rd;
    bus.in_wen     = wen;
    bus.in_is_load = is_load;
    bus.in_funct3  = f3;
    bus.in_result  = res;
  endtask

  // ALU op: handshake, one WRITE cycle, back to IDLE.
  task automatic alu_op(input string tag, input logic [4:0] rd, input logic [31:0] res,
                        input logic exp_wen);
    present(rd, 1'b1, 1'b0, 3'b000, res);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_outs({tag, ".write"}, 1'b0, 1'b0, exp_wen, 1'b1, 1'b0);
    chk({tag, ".waddr"}, {27'd0, bus.rf_waddr}, {27'd0, rd});
    chk({tag, ".wdata"}, bus.rf_wdata, res);
    @(negedge clk);
    chk_outs({tag, ".idle"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Load: handshake, 'waits' cycles without response, response cycle, WRITE, IDLE.
  task automatic load_op(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rdata, input logic rerr,
                         input int waits, input logic [31:0] exp_data, input logic exp_wen);
    present(rd, 1'b1, 1'b1, f3, addr);
    bus.mem_rdata = rdata;
    bus.mem_rerr  = rerr;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < waits; i++) begin
      chk_outs({tag, ".wait"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
    chk_outs({tag, ".resp"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.mem_rvalid = 1'b1;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    bus.mem_rerr   = 1'b0;
    chk_outs({tag, ".write"}, 1'b0, 1'b0, exp_wen, 1'b1, rerr);
    chk({tag, ".waddr"}, {27'd0, bus.rf_waddr}, {27'd0, rd});
    if (!rerr) chk({tag, ".wdata"}, bus.rf_wdata, exp_data);
    else       chk({tag, ".wb_err_hi"}, {31'd0, bus.wb_err}, 32'd1);
    @(negedge clk);
    chk_outs({tag, ".idle"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_assert       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_rd      = 5'd0;
    bus.in_wen     = 1'b0;
    bus.in_is_load = 1'b0;
    bus.in_funct3  = 3'b000;
    bus.in_result  = 32'h0000_0000;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0000_0000;
    bus.mem_rerr   = 1'b0;

    repeat (3) @(negedge clk);
    chk_outs("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.waddr", {27'd0, bus.rf_waddr}, 32'd0);
    chk("reset.wdata", bus.rf_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    alu_op("alu_rd5", 5'd5, 32'h1234_5678, 1'b1);
    alu_op("alu_rd0", 5'd0, 32'hFFFF_FFFF, 1'b0);

    load_op("lb_off3",  5'd7,  3'b000, 32'h0000_1003, 32'h80FF_0102, 1'b0, 4, 32'hFFFF_FF80, 1'b1);
    load_op("lbu_off3", 5'd8,  3'b100, 32'h0000_1003, 32'h80FF_0102, 1'b0, 0, 32'h0000_0080, 1'b1);
    load_op("lb_off1",  5'd8,  3'b000, 32'h0000_1001, 32'h80FF_0102, 1'b0, 1, 32'h0000_0001, 1'b1);
    load_op("lhu_off2", 5'd10, 3'b101, 32'h0000_2002, 32'h8001_0000, 1'b0, 0, 32'h0000_8001, 1'b1);
    load_op("lh_off2",  5'd11, 3'b001, 32'h0000_2002, 32'h8001_0000, 1'b0, 2, 32'hFFFF_8001, 1'b1);
    load_op("lw",       5'd12, 3'b010, 32'h0000_2000, 32'h8001_0000, 1'b0, 0, 32'h8001_0000, 1'b1);
    load_op("lh_off3",  5'd13, 3'b001, 32'h0000_1003, 32'h80FF_0102, 1'b0, 0, 32'h0000_0080, 1'b1);
    load_op("f3_111",   5'd14, 3'b111, 32'h0000_1001, 32'hDEAD_BEEF, 1'b0, 0, 32'hDEAD_BEEF, 1'b1);
    load_op("lw_rd0",   5'd0,  3'b010, 32'h0000_2000, 32'h5555_AAAA, 1'b0, 0, 32'h5555_AAAA, 1'b0);

    load_op("lw_fault", 5'd9, 3'b010, 32'h0000_3000, 32'h1111_2222, 1'b1, 1, 32'h0000_0000, 1'b0);
    alu_op("alu_after_fault", 5'd6, 32'h0BAD_F00D, 1'b1);

    // Reset while waiting for memory; the late response must be dropped.
    present(5'd15, 1'b1, 1'b1, 3'b010, 32'h0000_4000);
    bus.mem_rdata = 32'hCAFE_BABE;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_outs("rst_mid.wait", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk_outs("rst_mid.async", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.mem_rvalid = 1'b1;
    @(negedge clk);
    chk_outs("rst_mid.held", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.mem_rvalid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_outs("rst_mid.after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    alu_op("alu_after_rst", 5'd3, 32'h0000_A5A5, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
